input_arbiter: RTL

- Shares the single user-input resource (keypad/switch input unit) between two requesters:
  - the CPU data-memory path (memory-mapped input load);
  - the debug host (UART debug core requesting a user value).
- Grants one requester at a time, issues a one-cycle input_enable, waits for the user to confirm, captures the value and returns it with an ack.
- Sits between data_mem/debug core and the input unit. Drives a stall for the hazard unit.

---
 rtl/input_arbiter_if.sv | 39 +++
 rtl/input_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/input_arbiter_if.sv
// Handshake bundle between the input arbiter, its two requesters (CPU data
// path, debug host) and the keypad/switch input unit.
//   slave  : arbiter side (drives input_enable, acks, response, status)
//   master : environment side (drives requests and input-unit signals)
interface input_arbiter_if #(
  parameter int DATA_W     = 32,
  parameter int WAIT_CNT_W = 16
) ();
  logic                  cpu_req;
  logic                  dbg_req;
  logic                  input_enable;
  logic                  input_complete;
  logic                  switch_enable;
  logic [DATA_W-1:0]     keypad_data;
  logic [DATA_W-1:0]     switch_data;
  logic                  cpu_pause;
  logic                  cpu_ack;
  logic                  dbg_ack;
  logic [DATA_W-1:0]     resp_data;
  logic                  resp_from_switch;
  logic                  cpu_stall;
  logic                  busy;
  logic                  owner;
  logic [WAIT_CNT_W-1:0] last_wait;

  modport slave (
    input  cpu_req, dbg_req, input_complete, switch_enable,
           keypad_data, switch_data, cpu_pause,
    output input_enable, cpu_ack, dbg_ack, resp_data, resp_from_switch,
           cpu_stall, busy, owner, last_wait
  );

  modport master (
    output cpu_req, dbg_req, input_complete, switch_enable,
           keypad_data, switch_data, cpu_pause,
    input  input_enable, cpu_ack, dbg_ack, resp_data, resp_from_switch,
           cpu_stall, busy, owner, last_wait
  );
endinterface

// File: rtl/input_arbiter.sv
// Shares the keypad/switch input unit between the CPU load path and the debug
// host. One requester is granted at a time, the input unit gets a one-cycle
// input_enable, and the value captured on the user's enter press is returned
// with a one-cycle ack to whoever owns the grant.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - input_arbiter_if.slave: requests/acks, input-unit handshake,
//          response data and status (busy, owner, cpu_stall, last_wait)
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no transaction; arbitrate cpu_req / dbg_req
// ISSUE | input_enable high for this cycle; wait counter cleared
// WAIT  | wait for rising edge of input_complete; count unpaused cycles
// RESP  | ack to owner for this cycle; back to IDLE
module input_arbiter #(
  parameter int DATA_W     = 32,
  parameter int WAIT_CNT_W = 16
) (
  input logic            clk,
  input logic            rst,
  input_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_RESP  = 2'b11
  } state_t;

  localparam logic [WAIT_CNT_W-1:0] CNT_ONE = WAIT_CNT_W'(1);
  localparam logic [WAIT_CNT_W-1:0] CNT_MAX = '1;

  state_t                r_state;
  logic                  r_input_enable;
  logic                  r_cpu_ack;
  logic                  r_dbg_ack;
  logic                  r_resp_from_switch;
  logic                  r_owner;
  logic                  r_complete_q;
  logic [DATA_W-1:0]     r_resp_data;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic [WAIT_CNT_W-1:0] r_last_wait;
  logic                  w_complete_evt;

  // Only a fresh rising edge completes; a level left high by an earlier
  // entry must fall and rise again.
  assign w_complete_evt = bus.input_complete & ~r_complete_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state            <= S_IDLE;
      r_input_enable     <= 1'b0;
      r_cpu_ack          <= 1'b0;
      r_dbg_ack          <= 1'b0;
      r_resp_from_switch <= 1'b0;
      r_owner            <= 1'b1;  // debug as "last served" so CPU wins the first tie
      r_complete_q       <= 1'b0;
      r_resp_data        <= '0;
      r_wait_cnt         <= '0;
      r_last_wait        <= '0;
    end else begin
      r_complete_q   <= bus.input_complete;
      r_input_enable <= 1'b0;
      r_cpu_ack      <= 1'b0;
      r_dbg_ack      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.cpu_req | bus.dbg_req) begin
            // Tie goes to whoever was not served last.
            r_owner        <= (bus.cpu_req & bus.dbg_req) ? ~r_owner : bus.dbg_req;
            r_input_enable <= 1'b1;
            r_state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wait_cnt <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (w_complete_evt) begin
            r_resp_data        <= bus.switch_enable ? bus.switch_data : bus.keypad_data;
            r_resp_from_switch <= bus.switch_enable;
            r_last_wait        <= r_wait_cnt;
            if (r_owner) r_dbg_ack <= 1'b1;
            else         r_cpu_ack <= 1'b1;
            r_state <= S_RESP;
          end else if (!bus.cpu_pause && (r_wait_cnt != CNT_MAX)) begin
            r_wait_cnt <= r_wait_cnt + CNT_ONE;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.input_enable     = r_input_enable;
  assign bus.cpu_ack          = r_cpu_ack;
  assign bus.dbg_ack          = r_dbg_ack;
  assign bus.resp_data        = r_resp_data;
  assign bus.resp_from_switch = r_resp_from_switch;
  assign bus.owner            = r_owner;
  assign bus.last_wait        = r_last_wait;
  assign bus.busy             = (r_state != S_IDLE);
  assign bus.cpu_stall        = bus.cpu_req & ~r_cpu_ack;

endmodule
